// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative divider.
// Optional build macro: DIVIDER_EARLY_OUT_EN (leading-zero early out).
`ifndef XLEN
`define XLEN 64
`endif

package div_pkg;
  localparam int DIV_XLEN  = `XLEN;
  localparam int DIV_TAG_W = 5;
  localparam int ITER_W    = $clog2(DIV_XLEN + 1);

  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Per-operation controls captured at accept and used when finishing.
  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic rem_sel;
    logic word;
  } div_ctl_t;

  function automatic logic [DIV_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(DIV_XLEN-32){v[31]}}, v};
  endfunction
endpackage

// File: rtl/iter_divider_if.sv
// Issue/writeback handshake bundle for the divider.
interface iter_divider_if import div_pkg::*; #(
  parameter int XLEN  = DIV_XLEN,
  parameter int TAG_W = DIV_TAG_W
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
                  input  in_ready, out_valid, out_data, out_tag);
  modport slave  (input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
                  output in_ready, out_valid, out_data, out_tag);
endinterface

// File: rtl/iter_divider_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architectural result for those cases. Operands arrive already extended.
module div_special_detect import div_pkg::*; #(
  parameter int XLEN = DIV_XLEN
) (
  input  div_op_t         op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            div_zero,
  output logic            ovf,
  output logic [XLEN-1:0] res
);
  logic is_sgn, is_rem;

  // Flag corner cases and select their fixed result.
  always_comb begin
    is_sgn   = (op == DIV) || (op == REM);
    is_rem   = (op == REM) || (op == REMU);
    div_zero = (b == '0);
    if (is_word) ovf = is_sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    else         ovf = is_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    res = '0;
    if (div_zero)  res = is_rem ? a : '1;
    else if (ovf)  res = is_rem ? '0 : a;
    if (is_word) res = sext32(res[31:0]);
  end
endmodule

// File: rtl/iter_divider.sv
// Radix-2 non-restoring divider for RV64 DIV/DIVU/REM/REMU and W variants.
// Optional build macro: DIVIDER_EARLY_OUT_EN (skip leading-zero iterations).
module iter_divider import div_pkg::*; #(
  parameter int XLEN  = DIV_XLEN,
  parameter int TAG_W = DIV_TAG_W
) (
  input logic         clk,
  input logic         rst,
  iter_divider_if.slave bus
);
  div_state_t        state;
  div_ctl_t          ctl;
  logic [ITER_W-1:0] cnt;
  logic [XLEN+1:0]   p;     // signed partial remainder, one guard bit over 2*divisor
  logic [XLEN-1:0]   q;     // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0]   dvs;

  logic              is_word, is_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic [ITER_W-1:0] shamt, iters;
  logic              div_zero, ovf, fast;
  logic [XLEN-1:0]   sp_res, fast_res;

  // Operand extension for W-ops and magnitude conversion for signed ops.
  always_comb begin
    is_word = bus.in_op[2];
    is_sgn  = ~bus.in_op[0];
    if (is_word) begin
      a_ext = is_sgn ? sext32(bus.in_a[31:0]) : {{(XLEN-32){1'b0}}, bus.in_a[31:0]};
      b_ext = is_sgn ? sext32(bus.in_b[31:0]) : {{(XLEN-32){1'b0}}, bus.in_b[31:0]};
    end else begin
      a_ext = bus.in_a;
      b_ext = bus.in_b;
    end
    a_neg = is_sgn & a_ext[XLEN-1];
    b_neg = is_sgn & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  div_special_detect #(.XLEN(XLEN)) u_special (
    .op       (div_op_t'(bus.in_op[1:0])),
    .is_word  (is_word),
    .a        (a_ext),
    .b        (b_ext),
    .div_zero (div_zero),
    .ovf      (ovf),
    .res      (sp_res)
  );

`ifdef DIVIDER_EARLY_OUT_EN
  logic [ITER_W-1:0] clz;
  // Pre-shift past the dividend's leading zeros; a zero dividend finishes at once.
  always_comb begin
    clz = ITER_W'(XLEN);
    for (int i = 0; i < XLEN; i++) if (a_mag[i]) clz = ITER_W'(XLEN - 1 - i);
    shamt    = clz;
    iters    = ITER_W'(XLEN) - clz;
    fast     = div_zero | ovf | (a_mag == '0);
    fast_res = (div_zero | ovf) ? sp_res : '0;
  end
`else
  // Fixed iteration count; W-op magnitudes are aligned to the top bit.
  always_comb begin
    shamt    = is_word ? ITER_W'(XLEN - 32) : '0;
    iters    = is_word ? ITER_W'(32) : ITER_W'(XLEN);
    fast     = div_zero | ovf;
    fast_res = sp_res;
  end
`endif

  logic [XLEN+1:0] p_sh, p_nx;
  logic [XLEN-1:0] q_nx, r_fix, q_fin, r_fin, res;

  // One non-restoring step, plus remainder correction and sign fix-up.
  always_comb begin
    p_sh  = {p[XLEN:0], q[XLEN-1]};
    p_nx  = p[XLEN+1] ? p_sh + {2'b00, dvs} : p_sh - {2'b00, dvs};
    q_nx  = {q[XLEN-2:0], ~p_nx[XLEN+1]};
    r_fix = p[XLEN-1:0] + (p[XLEN+1] ? dvs : '0);
    q_fin = ctl.q_neg ? -q : q;
    r_fin = ctl.r_neg ? -r_fix : r_fix;
    res   = ctl.rem_sel ? r_fin : q_fin;
    if (ctl.word) res = sext32(res[31:0]);
  end

  // Control FSM: accept, iterate, hold the result until writeback takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_tag   <= '0;
      ctl           <= '0;
      cnt           <= '0;
      p             <= '0;
      q             <= '0;
      dvs           <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          bus.in_ready <= 1'b0;
          bus.out_tag  <= bus.in_tag;
          if (fast) begin
            bus.out_data  <= fast_res;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            p           <= '0;
            q           <= a_mag << shamt;
            dvs         <= b_mag;
            cnt         <= iters;
            ctl.q_neg   <= a_neg ^ b_neg;
            ctl.r_neg   <= a_neg;
            ctl.rem_sel <= bus.in_op[1];
            ctl.word    <= is_word;
            state       <= CALC;
          end
        end
        CALC: if (cnt != '0) begin
          p   <= p_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
        end else begin
          bus.out_data  <= res;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// Directed + randomized bench for iter_divider against an arithmetic reference.
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  iter_divider_if #(.XLEN(64), .TAG_W(5)) ifc ();
  iter_divider dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from the ISA rules using native signed/unsigned division.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sgn, rem;
    logic [31:0] r32;
    int sa32, sb32;
    longint sa, sb;
    sgn = !op[1] ? !op[0] : !op[0];
    rem = op[1];
    if (op[2]) begin
      sa32 = int'(a[31:0]);
      sb32 = int'(b[31:0]);
      if (b[31:0] == 32'h0)                                    r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (sgn && a[31:0] == 32'h8000_0000 && sb32 == -1)  r32 = rem ? 32'h0 : a[31:0];
      else if (sgn)                                            r32 = rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      else                                                     r32 = rem ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      return {{32{r32[31]}}, r32};
    end
    sa = longint'(a);
    sb = longint'(b);
    if (b == 64'h0) return rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return rem ? 64'h0 : a;
    if (sgn) return rem ? 64'(sa % sb) : 64'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Expected cycles from accept to out_valid.
  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sgn, word;
    logic [63:0] ae, be, mag;
    int n;
    sgn  = !op[0];
    word = op[2];
    ae = word ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
    be = word ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
    if (be == 64'h0) return 1;
    if (sgn && be == 64'hFFFF_FFFF_FFFF_FFFF &&
        ae == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
`ifdef DIVIDER_EARLY_OUT_EN
    mag = (sgn && ae[63]) ? -ae : ae;
    if (mag == 64'h0) return 1;
    n = 0;
    while (mag != 64'h0) begin n++; mag = mag >> 1; end
    return n + 2;
`else
    mag = 64'h0;
    n = mag[0] ? 1 : 0;
    return (word ? 34 : 66) + n;
`endif
  endfunction

  task automatic wait_ready(input string name);
    int g = 0;
    @(negedge clk);
    while (!ifc.in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk({name, ".ready_timeout"}, 64'(g), 64'(0));
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_tag   = tag;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  // Issue one op, measure latency, check data/tag; out_ready is high so it pops next edge.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic [63:0] exp, input string name);
    int lat;
    wait_ready(name);
    issue(op, a, b, tag);
    lat = 1;
    while (!ifc.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({name, ".lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
    chk({name, ".data"}, ifc.out_data, exp);
    chk({name, ".tag"}, 64'(ifc.out_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] A0 = 64'hFF22_3344_5566_7788;
  localparam logic [63:0] B0 = 64'h0000_0000_AABB_0077;
  localparam logic [63:0] A1 = 64'h0000_0000_AABB_0077;
  localparam logic [63:0] B1 = 64'h0000_0000_0000_1234;
  localparam logic [63:0] MN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b, held_d;
    logic [4:0]  tag;
    logic        seen;
    int          g;

    rst = 1'b1;
    ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.in_op = '0;
    ifc.in_a = '0; ifc.in_b = '0; ifc.in_tag = '0; ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(ifc.in_ready), 64'(1));
    chk("reset.out_valid", 64'(ifc.out_valid), 64'(0));
    chk("reset.out_data", ifc.out_data, 64'h0);
    chk("reset.out_tag", 64'(ifc.out_tag), 64'(0));
    @(negedge clk); rst = 1'b0;

    // 64-bit normal path
    run_op(3'b000, A0, B0, 5'd1, 64'hFFFF_FFFF_FEB3_6CBC, "div");
    run_op(3'b001, A0, B0, 5'd2, 64'h0000_0001_7E8E_AF33, "divu");
    run_op(3'b010, A0, B0, 5'd3, 64'hFFFF_FFFF_AAAA_EC24, "rem");
    run_op(3'b011, A0, B0, 5'd4, 64'h0000_0000_A8D2_06D3, "remu");
    // W-ops
    run_op(3'b100, A1, B1, 5'd5, 64'hFFFF_FFFF_FFFB_50D0, "divw");
    run_op(3'b111, A1, B1, 5'd6, 64'h0000_0000_0000_04CF, "remuw");
    run_op(3'b101, A1, B1, 5'd7, 64'h0000_0000_0009_6112, "divuw");
    // divide by zero
    run_op(3'b000, A0, 64'h0, 5'd8,  M1, "div0");
    run_op(3'b001, A0, 64'h0, 5'd9,  M1, "divu0");
    run_op(3'b010, A0, 64'h0, 5'd10, A0, "rem0");
    run_op(3'b011, A0, 64'h0, 5'd11, A0, "remu0");
    run_op(3'b110, A0, 64'h0, 5'd12, 64'h0000_0000_5566_7788, "remw0");
    run_op(3'b111, A0, 64'h0, 5'd13, 64'h0000_0000_5566_7788, "remuw0");
    // signed overflow
    run_op(3'b000, MN, M1, 5'd14, MN, "ovf_div");
    run_op(3'b010, MN, M1, 5'd15, 64'h0, "ovf_rem");
    run_op(3'b100, 64'h8000_0000, M1, 5'd16, 64'hFFFF_FFFF_8000_0000, "ovf_divw");
    run_op(3'b110, 64'h8000_0000, M1, 5'd17, 64'h0, "ovf_remw");
    // short dividends (early-out exercise when enabled)
    run_op(3'b001, 64'h1, 64'h1, 5'd18, 64'h1, "divu_1_1");
    run_op(3'b000, 64'h0, 64'h5, 5'd19, 64'h0, "div_zero_dvd");

    // backpressure: result and tag hold, no new accept
    wait_ready("bp");
    ifc.out_ready = 1'b0;
    issue(3'b010, A0, B0, 5'd21);
    g = 0;
    while (!ifc.out_valid && g < 200) begin @(posedge clk); #1; g++; end
    held_d = ref_res(3'b010, A0, B0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp.data", ifc.out_data, held_d);
      chk("bp.tag", 64'(ifc.out_tag), 64'(21));
      chk("bp.in_ready", 64'(ifc.in_ready), 64'(0));
      chk("bp.out_valid", 64'(ifc.out_valid), 64'(1));
    end
    @(negedge clk); ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.pop_valid", 64'(ifc.out_valid), 64'(0));
    chk("bp.pop_ready", 64'(ifc.in_ready), 64'(1));

    // flush mid-CALC
    wait_ready("flush");
    issue(3'b001, A0, B0, 5'd22);
    repeat (5) @(posedge clk);
    @(negedge clk); ifc.flush = 1'b1;
    @(posedge clk); #1; ifc.flush = 1'b0;
    chk("flush.in_ready", 64'(ifc.in_ready), 64'(1));
    chk("flush.out_valid", 64'(ifc.out_valid), 64'(0));
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (ifc.out_valid) seen = 1'b1; end
    chk("flush.no_result", 64'(seen), 64'(0));
    run_op(3'b000, A0, B0, 5'd23, 64'hFFFF_FFFF_FEB3_6CBC, "after_flush");

    // flush together with an accept drops the request
    @(negedge clk);
    ifc.flush = 1'b1;
    issue(3'b000, A0, 64'h0, 5'd24);
    ifc.flush = 1'b0;
    chk("flush_acc.in_ready", 64'(ifc.in_ready), 64'(1));
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (ifc.out_valid) seen = 1'b1; end
    chk("flush_acc.no_result", 64'(seen), 64'(0));

    // randomized ops with corner biasing
    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      tag = 5'($urandom);
      case ($urandom_range(0, 6))
        0: b = 64'($urandom_range(1, 300));
        1: b = 64'h0;
        2: a = 64'($urandom_range(0, 1000));
        3: b = {32'h0, $urandom};
        4: begin a = MN; b = M1; end
        5: b = -64'($urandom_range(1, 50));
        default: ;
      endcase
      run_op(op, a, b, tag, ref_res(op, a, b), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Iterative radix-2 non-restoring integer divider that executes the RV64 M-extension DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW operations. It sits in the execute stage of the core as the divide functional unit. It accepts one operation per handshake from issue and returns the result, with its destination register tag, to writeback. It also resolves the architectural corner cases (divide-by-zero, signed overflow) on a single-cycle fast path.

Parameters:
XLEN, `XLEN (64), datapath width; W-ops operate on the low 32 bits.
TAG_W, 5, width of the destination register tag passed through.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  abandon any in-flight op; no result is produced
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request (high only in IDLE)
in_op  in  3  {is_word, funct3[1:0]}: 00=DIV, 01=DIVU, 10=REM, 11=REMU
in_a  in  XLEN  dividend (rs1)
in_b  in  XLEN  divisor (rs2)
in_tag  in  TAG_W  destination register
out_valid  out  1  result valid
out_ready  in  1  writeback accepts the result
out_data  out  XLEN  result; W-ops are sign-extended from bit 31
out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_tag=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: a transfer occurs when in_valid&&in_ready. On transfer, latch op and tag; for W-ops, truncate operands to 32 bits and sign- or zero-extend them per signedness.
- Special cases (checked at accept, go straight to DONE the next cycle):
  - divisor==0: quotient = all ones; remainder = dividend (W: sign-extended low 32 bits).
  - signed op with dividend = most negative value and divisor = -1: quotient = dividend, remainder = 0.
- Normal path: operate on operand magnitudes. Iterations N = XLEN, or 32 for W-ops. One quotient bit per cycle in CALC.
- After the final iteration: apply the remainder correction, then negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative (signed ops only). Then go to DONE.
- Latency from accept to out_valid: 1 cycle for special cases; N+2 cycles otherwise (66 for 64-bit, 34 for W-ops).
- DONE: out_valid=1. out_data and out_tag stay stable until out_valid&&out_ready, then return to IDLE with out_valid=0. The result must not change while out_ready=0.
- in_ready=0 in CALC and DONE. There is no accept in the same cycle a result leaves; the next accept is earliest in the following cycle.
- flush: in any state, the next state is IDLE and out_valid=0. flush in the same cycle as an accept drops that request. rst has priority over flush.
- W-op result: bit 31 of the 32-bit quotient/remainder is replicated into bits 63:32, including on the special-case paths.

Optional Feature:
DIVIDER_EARLY_OUT_EN: when defined, at accept compute the leading-zero count of the dividend magnitude, pre-shift by that amount, and perform only N-clz iterations. A zero dividend goes to DONE after 1 cycle. Results are bit-identical. When undefined, latency is fixed as given above.

Decomposition:
- Package div_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU)
  - div_state_t enum (IDLE, CALC, DONE)
  - localparam ITER_W = $clog2(XLEN+1)
  - helper function sext32
- One natural sub-module, div_special_detect (combinational): flags divide-by-zero and overflow, and produces the fast-path result from op, a, b.

Test Plan:
- a=0xFF22334455667788, b=0xAABB0077: DIV->0xFFFFFFFFFEB36CBC, DIVU->0x17E8EAF33, REM->0xFFFFFFFFAAAAEC24, REMU->0xA8D206D3, each out_valid exactly 66 cycles after accept (macro off).
- a=0xAABB0077, b=0x1234: DIVW->0xFFFFFFFFFFFB50D0, REMUW->0x4CF, DIVUW->0x96112; latency 34 cycles.
- b=0 with a=0xFF22334455667788: DIV/DIVU->all ones, REM/REMU->a; REMW/REMUW->0x55667788; out_valid 1 cycle after accept.
- Overflow: DIV 0x8000000000000000/-1 -> 0x8000000000000000 and REM->0; DIVW 0x80000000/-1 -> 0xFFFFFFFF80000000 and REMW->0.
- Backpressure/flush: hold out_ready=0 for 10 cycles -> out_data and out_tag stable and in_ready=0; assert flush mid-CALC -> IDLE next cycle, no out_valid, next op correct.
- Macro on: DIVU a=1, b=1 -> 1 in ≤4 cycles; a=0 -> 0 after 1 cycle; all results above unchanged.
